// File: rtl/dmem_axi_slave_pkg.sv
// Shared types for the data-memory AXI responder: response codes, FSM states, burst length width.
package dmem_axi_slave_pkg;
   localparam int AXI_LEN_WIDTH = 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axi_resp_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;
endpackage

// File: rtl/dmem_axi_slave_if.sv
// AXI4-style read (AR/R) and write (AW/W/B) channel bundles with master/slave views.
interface axi_read_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]                         araddr;
   logic [dmem_axi_slave_pkg::AXI_LEN_WIDTH-1:0]  arlen;
   logic                                          arvalid;
   logic                                          arready;
   logic [DATA_WIDTH-1:0]                         rdata;
   logic [1:0]                                    rresp;
   logic                                          rlast;
   logic                                          rvalid;
   logic                                          rready;

   modport slave  (input  araddr, arlen, arvalid, rready,
                   output arready, rdata, rresp, rlast, rvalid);
   modport master (output araddr, arlen, arvalid, rready,
                   input  arready, rdata, rresp, rlast, rvalid);
endinterface

interface axi_write_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]                         awaddr;
   logic [dmem_axi_slave_pkg::AXI_LEN_WIDTH-1:0]  awlen;
   logic                                          awvalid;
   logic                                          awready;
   logic [DATA_WIDTH-1:0]                         wdata;
   logic [DATA_WIDTH/8-1:0]                       wstrb;
   logic                                          wlast;
   logic                                          wvalid;
   logic                                          wready;
   logic [1:0]                                    bresp;
   logic                                          bvalid;
   logic                                          bready;

   modport slave  (input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
                   output awready, wready, bresp, bvalid);
   modport master (output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
                   input  awready, wready, bresp, bvalid);
endinterface

// File: rtl/dmem_axi_slave_ram.sv
// Word RAM, 1-cycle synchronous read, byte-enabled write; a same-cycle read of the written word returns old data.
module dmem_ram #(
   parameter int DEPTH     = 1024,
   parameter int WIDTH     = 32,
   parameter int IDX_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   ren,
   input  logic [IDX_WIDTH-1:0]   ridx,
   output logic [WIDTH-1:0]       rdat,
   input  logic                   we,
   input  logic [IDX_WIDTH-1:0]   widx,
   input  logic [WIDTH-1:0]       wdat,
   input  logic [WIDTH/8-1:0]     wstrb
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (ren) begin
         rdat <= mem[ridx];
      end
      if (we) begin
         for (int b = 0; b < WIDTH/8; b++) begin
            if (wstrb[b]) begin
               mem[widx][8*b +: 8] <= wdat[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: rtl/dmem_axi_slave.sv
// INCR-burst AXI responder over dmem_ram: rvalid 2 cycles after AR, 1 beat/2 cycles; R held while !rready, B held until bready.
module dmem_axi_slave
   import dmem_axi_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst_n,
   axi_read_if.slave   rd,
   axi_write_if.slave  wr
);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> 2) < MEM_DEPTH);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IW'((a - BASE_ADDR) >> 2);
   endfunction

   rd_state_e               r_state, r_next;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [AXI_LEN_WIDTH-1:0] r_len, r_cnt;
   logic                    r_ren;
   logic [DATA_WIDTH-1:0]   ram_q;

   wr_state_e               w_state, w_next;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [AXI_LEN_WIDTH-1:0] w_len, w_cnt;
   logic                    w_err;
   logic                    w_we;

   logic [IW-1:0]           r_idx, w_idx;
   assign r_idx = word_idx(r_addr);
   assign w_idx = word_idx(w_addr);

   dmem_ram #(
      .DEPTH     (MEM_DEPTH),
      .WIDTH     (DATA_WIDTH),
      .IDX_WIDTH (IW)
   ) u_ram (
      .clk   (clk),
      .ren   (r_ren),
      .ridx  (r_idx),
      .rdat  (ram_q),
      .we    (w_we),
      .widx  (w_idx),
      .wdat  (wr.wdata),
      .wstrb (wr.wstrb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= r_next;
         case (r_state)
            R_IDLE: if (rd.arvalid) begin
               r_addr <= rd.araddr;
               r_len  <= rd.arlen;
               r_cnt  <= '0;
            end
            R_DATA: if (rd.rready && (r_cnt != r_len)) begin
               r_addr <= r_addr + ADDR_WIDTH'(4);
               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ram_q is only refreshed in R_FETCH, so R_DATA outputs stay put while stalled.
   always_comb begin
      r_next     = r_state;
      r_ren      = 1'b0;
      rd.arready = 1'b0;
      rd.rvalid  = 1'b0;
      rd.rlast   = 1'b0;
      rd.rdata   = '0;
      rd.rresp   = OKAY;
      case (r_state)
         R_IDLE: begin
            rd.arready = 1'b1;
            if (rd.arvalid) r_next = R_FETCH;
         end
         R_FETCH: begin
            r_ren  = 1'b1;
            r_next = R_DATA;
         end
         R_DATA: begin
            rd.rvalid = 1'b1;
            rd.rlast  = (r_cnt == r_len);
            if (in_range(r_addr)) rd.rdata = ram_q;
            else                  rd.rresp = SLVERR;
            if (rd.rready) r_next = (r_cnt == r_len) ? R_IDLE : R_FETCH;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else begin
         w_state <= w_next;
         case (w_state)
            W_IDLE: if (wr.awvalid) begin
               w_addr <= wr.awaddr;
               w_len  <= wr.awlen;
               w_cnt  <= '0;
               w_err  <= 1'b0;
            end
            W_DATA: if (wr.wvalid) begin
               // Burst length is governed by awlen; a misplaced wlast only taints the response.
               if (!in_range(w_addr) || (wr.wlast != (w_cnt == w_len))) w_err <= 1'b1;
               if (w_cnt != w_len) begin
                  w_addr <= w_addr + ADDR_WIDTH'(4);
                  w_cnt  <= w_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next     = w_state;
      w_we       = 1'b0;
      wr.awready = 1'b0;
      wr.wready  = 1'b0;
      wr.bvalid  = 1'b0;
      wr.bresp   = OKAY;
      case (w_state)
         W_IDLE: begin
            wr.awready = 1'b1;
            if (wr.awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            wr.wready = 1'b1;
            w_we      = wr.wvalid && in_range(w_addr);
            if (wr.wvalid && (w_cnt == w_len)) w_next = W_RESP;
         end
         W_RESP: begin
            wr.bvalid = 1'b1;
            wr.bresp  = w_err ? SLVERR : OKAY;
            if (wr.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dmem_axi_slave.sv
// Randomised bench for dmem_axi_slave against a word-array memory model with per-beat range rules.
module tb_dmem_axi_slave;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk;
   logic rst_n;

   axi_read_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rif ();
   axi_write_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wif ();

   dmem_axi_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rd    (rif),
      .wr    (wif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mdl   [DEPTH];
   bit          known [DEPTH];
   logic [31:0] wd_q  [256];
   logic [3:0]  ws_q  [256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit mdl_in_range(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
   endfunction

   task automatic do_write(input logic [31:0] addr, input int len, input int wlast_at, input bit early_w);
      int          t;
      bit          err;
      logic [31:0] a;
      int          idx;
      @(negedge clk);
      if (early_w) begin
         wif.wvalid = 1'b1; wif.wdata = 32'hBAD0_BAD0; wif.wstrb = 4'hF; wif.wlast = 1'b1;
         @(negedge clk);
         check("wready_before_aw", 32'(wif.wready), 0);
      end
      wif.awaddr = addr; wif.awlen = 8'(len); wif.awvalid = 1'b1;
      t = 0;
      while (!wif.awready && t < 100) begin @(negedge clk); t++; end
      if (!wif.awready) check("aw_timeout", 0, 1);
      @(negedge clk);
      wif.awvalid = 1'b0; wif.wvalid = 1'b0;
      err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wif.wvalid = 1'b0;
            @(negedge clk);
         end
         wif.wvalid = 1'b1; wif.wdata = wd_q[i]; wif.wstrb = ws_q[i]; wif.wlast = (i == wlast_at);
         t = 0;
         while (!wif.wready && t < 100) begin @(negedge clk); t++; end
         if (!wif.wready) check("w_timeout", 0, 1);
         a = addr + 32'(4 * i);
         if (mdl_in_range(a)) begin
            idx = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++)
               if (ws_q[i][b]) mdl[idx][8*b +: 8] = wd_q[i][8*b +: 8];
            if (ws_q[i] == 4'hF) known[idx] = 1'b1;
         end else begin
            err = 1'b1;
         end
         if ((i == wlast_at) != (i == len)) err = 1'b1;
         @(negedge clk);
      end
      wif.wvalid = 1'b0; wif.wlast = 1'b0;
      t = 0;
      while (!wif.bvalid && t < 100) begin @(negedge clk); t++; end
      check("bvalid", 32'(wif.bvalid), 1);
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         check("bvalid_hold", 32'(wif.bvalid), 1);
      end
      check("bresp", 32'(wif.bresp), err ? 32'h2 : 32'h0);
      wif.bready = 1'b1;
      @(negedge clk);
      wif.bready = 1'b0;
      check("bvalid_drop", 32'(wif.bvalid), 0);
      check("awready_after_b", 32'(wif.awready), 1);
   endtask

   // mode: 0 random rready, 1 rready toggling every cycle, 2 rready always high
   task automatic do_read(input logic [31:0] addr, input int len, input int mode);
      int          t, beat, cyc, idx;
      bit          stalled, tog, rr;
      logic [31:0] pd, a;
      logic [1:0]  pr;
      logic        pl;
      @(negedge clk);
      rif.araddr = addr; rif.arlen = 8'(len); rif.arvalid = 1'b1;
      t = 0;
      while (!rif.arready && t < 100) begin @(negedge clk); t++; end
      if (!rif.arready) check("ar_timeout", 0, 1);
      @(negedge clk);
      rif.arvalid = 1'b0;
      check("r_latency_fetch", 32'(rif.rvalid), 0);
      @(negedge clk);
      check("r_latency_data", 32'(rif.rvalid), 1);
      beat = 0; cyc = 0; stalled = 1'b0; tog = 1'b0;
      pd = '0; pr = '0; pl = 1'b0;
      while (beat <= len && cyc < 5000) begin
         if (stalled) begin
            check("r_hold_vld",  32'(rif.rvalid), 1);
            check("r_hold_data", rif.rdata, pd);
            check("r_hold_resp", 32'(rif.rresp), 32'(pr));
            check("r_hold_last", 32'(rif.rlast), 32'(pl));
         end
         if (rif.rvalid) begin
            case (mode)
               0:       rr = 1'($urandom_range(0, 1));
               1:       rr = tog;
               default: rr = 1'b1;
            endcase
            rif.rready = rr;
            if (rr) begin
               a = addr + 32'(4 * beat);
               if (mdl_in_range(a)) begin
                  idx = int'((a - BASE) >> 2);
                  check("r_resp", 32'(rif.rresp), 0);
                  if (known[idx]) check("r_data", rif.rdata, mdl[idx]);
               end else begin
                  check("r_resp_oor", 32'(rif.rresp), 2);
                  check("r_data_oor", rif.rdata, 0);
               end
               check("r_last", 32'(rif.rlast), 32'(beat == len));
               beat++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               pd = rif.rdata; pr = rif.rresp; pl = rif.rlast;
            end
         end else begin
            rif.rready = 1'b0;
            stalled = 1'b0;
         end
         tog = ~tog;
         @(negedge clk);
         cyc++;
      end
      rif.rready = 1'b0;
      if (beat <= len) check("r_timeout_beats", 32'(beat), 32'(len + 1));
      repeat (2) begin
         check("r_no_extra_beat", 32'(rif.rvalid), 0);
         check("arready_after_r", 32'(rif.arready), 1);
         @(negedge clk);
      end
   endtask

   task automatic fill(input int len, input bit rnd_strb);
      for (int i = 0; i <= len; i++) begin
         wd_q[i] = $urandom;
         ws_q[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          beats, t, len, wl;
      logic [31:0] a;
      rst_n = 1'b0;
      rif.araddr = '0; rif.arlen = '0; rif.arvalid = 1'b0; rif.rready = 1'b0;
      wif.awaddr = '0; wif.awlen = '0; wif.awvalid = 1'b0;
      wif.wdata = '0; wif.wstrb = '0; wif.wlast = 1'b0; wif.wvalid = 1'b0; wif.bready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_arready", 32'(rif.arready), 1);
      check("rst_awready", 32'(wif.awready), 1);
      check("rst_rvalid",  32'(rif.rvalid), 0);
      check("rst_rlast",   32'(rif.rlast), 0);
      check("rst_rdata",   rif.rdata, 0);
      check("rst_rresp",   32'(rif.rresp), 0);
      check("rst_wready",  32'(wif.wready), 0);
      check("rst_bvalid",  32'(wif.bvalid), 0);
      check("rst_bresp",   32'(wif.bresp), 0);

      for (int i = 0; i < 4; i++) begin wd_q[i] = 32'hA0 + 32'(i); ws_q[i] = 4'hF; end
      do_write(32'h10, 3, 3, 1'b0);
      do_read(32'h10, 3, 2);

      wd_q[0] = 32'hDEAD_BEEF; ws_q[0] = 4'hF;
      do_write(32'h20, 0, 0, 1'b1);
      wd_q[0] = 32'h0000_00AA; ws_q[0] = 4'b0001;
      do_write(32'h20, 0, 0, 1'b0);
      do_read(32'h20, 0, 2);
      check("partial_strobe_model", mdl[8], 32'hDEAD_BEAA);

      do_read(32'h10, 1, 1);

      fill(1, 1'b0);
      do_write(32'(4 * (DEPTH - 1)), 1, 1, 1'b0);
      do_read(32'(4 * (DEPTH - 1)), 1, 0);

      fill(2, 1'b0);
      do_write(32'h40, 2, 1, 1'b0);
      do_read(32'h40, 2, 2);

      // reset during beat 2 of an 8-beat read; committed writes must survive
      fill(7, 1'b0);
      do_write(32'h100, 7, 7, 1'b0);
      @(negedge clk);
      rif.araddr = 32'h100; rif.arlen = 8'd7; rif.arvalid = 1'b1;
      @(negedge clk);
      rif.arvalid = 1'b0; rif.rready = 1'b1;
      beats = 0; t = 0;
      while (!(rif.rvalid && beats == 2) && t < 100) begin
         if (rif.rvalid) beats++;
         @(negedge clk);
         t++;
      end
      check("mid_reset_reach_beat2", 32'(beats), 2);
      rif.rready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_reset_rvalid", 32'(rif.rvalid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_reset_arready", 32'(rif.arready), 1);
         check("post_reset_rvalid", 32'(rif.rvalid), 0);
      end
      do_read(32'h100, 7, 0);

      for (int it = 0; it < 10; it++) begin
         a   = 32'($urandom_range(0, DEPTH + 6)) * 4 + 32'($urandom_range(0, 3));
         len = $urandom_range(0, 15);
         wl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
         fill(len, ($urandom_range(0, 2) == 0));
         do_write(a, len, wl, 1'($urandom_range(0, 1)));
         do_read(a, $urandom_range(0, 15), $urandom_range(0, 2));
      end

      fill(7, 1'b0);
      fork
         do_write(32'h800, 7, 7, 1'b0);
         do_read(32'h10, 3, 0);
      join
      do_read(32'h800, 7, 2);

      fill(255, 1'b0);
      do_write(32'h0, 255, 255, 1'b0);
      do_read(32'h0, 255, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
